// File: rtl/axi_pkt_fifo_if.sv
// rtl/axi_pkt_fifo_if.sv - stream handshake bundle (tdata/tuser/tlast with valid/ready)
interface axi_pkt_fifo_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int TUSER_WIDTH = 8
);
    logic                   tvalid;
    logic                   tready;
    logic [DATA_WIDTH-1:0]  tdata;
    logic [TUSER_WIDTH-1:0] tuser;
    logic                   tlast;

    modport master (output tvalid, output tdata, output tuser, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tuser, input tlast, output tready);
endinterface

// File: rtl/axi_pkt_fifo.sv
// rtl/axi_pkt_fifo.sv - store-and-forward packet FIFO that drops overflowing packets
module axi_pkt_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int TUSER_WIDTH = 8,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  sync_reset,
    axi_pkt_fifo_if.slave         s_axis,
    axi_pkt_fifo_if.master        m_axis,
    output logic                  pkt_drop,
    output logic [ADDR_WIDTH:0]   pkt_cnt
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int EW    = 1 + TUSER_WIDTH + DATA_WIDTH;

    typedef enum logic {ST_ACCEPT = 1'b0, ST_DROP = 1'b1} state_t;

    logic [EW-1:0]           mem [DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           wr_commit;
    logic [PW-1:0]           commit_vis;
    logic [PW-1:0]           rd_ptr;
    logic [PW-1:0]           used;
    logic                    full;
    logic                    accept;
    logic                    wr_en;
    logic                    ovf;
    logic                    drop_done;
    logic                    load;
    logic                    out_valid;
    logic [DATA_WIDTH-1:0]   out_data;
    logic [TUSER_WIDTH-1:0]  out_user;
    logic                    out_last;
    logic                    inc_cnt;
    logic                    dec_cnt;
    state_t                  state;
    state_t                  state_next;

    // Overflow is resolved by dropping, so the input never backpressures.
    assign s_axis.tready = ~sync_reset;
    assign accept        = s_axis.tvalid & ~sync_reset;
    assign used          = wr_ptr - rd_ptr;
    assign full          = (used == PW'(DEPTH));

    assign m_axis.tvalid = out_valid;
    assign m_axis.tdata  = out_data;
    assign m_axis.tuser  = out_user;
    assign m_axis.tlast  = out_last;

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (sync_reset) state <= ST_ACCEPT;
        else            state <= state_next;
    end

    // Write FSM next state: enter DROP on a mid-packet overflow, leave on that packet's tlast.
    always_comb begin
        state_next = state;
        case (state)
            ST_ACCEPT: if (ovf && !s_axis.tlast) state_next = ST_DROP;
            ST_DROP:   if (accept && s_axis.tlast) state_next = ST_ACCEPT;
            default:   state_next = ST_ACCEPT;
        endcase
    end

    // Write FSM outputs: store, rewind-on-overflow and drop-complete strobes.
    always_comb begin
        wr_en     = 1'b0;
        ovf       = 1'b0;
        drop_done = 1'b0;
        case (state)
            ST_ACCEPT: begin
                wr_en     = accept & ~full;
                ovf       = accept & full;
                drop_done = accept & full & s_axis.tlast;
            end
            ST_DROP: begin
                drop_done = accept & s_axis.tlast;
            end
            default: ;
        endcase
    end

    // Beat storage; contents are don't-care until covered by wr_commit.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis.tlast, s_axis.tuser, s_axis.tdata};
    end

    // Write pointers; commit_vis delays the committed pointer one cycle toward the read side.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            wr_ptr     <= '0;
            wr_commit  <= '0;
            commit_vis <= '0;
        end else begin
            commit_vis <= wr_commit;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
                if (s_axis.tlast) wr_commit <= wr_ptr + PW'(1);
            end else if (ovf) begin
                wr_ptr <= wr_commit;
            end
        end
    end

    assign load = (~out_valid | m_axis.tready) & (rd_ptr != commit_vis);

    // Output register: refill whenever it is free or being consumed and committed data exists.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            rd_ptr    <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            rd_ptr    <= rd_ptr + PW'(1);
            out_valid <= 1'b1;
            {out_last, out_user, out_data} <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        end else if (m_axis.tready) begin
            out_valid <= 1'b0;
        end
    end

    assign inc_cnt = wr_en & s_axis.tlast;
    assign dec_cnt = out_valid & m_axis.tready & out_last;

    // Complete-packet count; commit and last-read in one cycle cancel.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            pkt_cnt <= '0;
        end else begin
            case ({inc_cnt, dec_cnt})
                2'b10:   pkt_cnt <= pkt_cnt + PW'(1);
                2'b01:   pkt_cnt <= pkt_cnt - PW'(1);
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

    // Single-cycle drop indication after the discarded packet's tlast.
    always_ff @(posedge clk) begin
        if (sync_reset) pkt_drop <= 1'b0;
        else            pkt_drop <= drop_done;
    end
endmodule
